byte_word_bridge: RTL and testbench

- Parametrised byte-serial bridge between the 8-bit pin interface and a DATA_W-wide synchronous RAM, such as the CPU instruction and program memories.
- Load path assembles incoming bytes little-endian into words and writes them to auto-incrementing addresses.
- Readout path fetches a burst of words and streams them out one byte at a time with a valid/ready handshake.
- Replaces the ad-hoc fixed 32-bit, free-running output byte rotator with a flow-controlled, burst-capable engine.

---
 rtl/byte_word_bridge_pkg.sv | 34 +++
 rtl/bwb_word_shifter.sv | 64 ++++++
 rtl/byte_word_bridge.sv | 188 ++++++++++++++++++
 tb/tb_byte_word_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_word_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : byte_word_bridge_pkg
// Description : Shared definitions for the byte/word bridge: FSM state
//               encodings and the helpers that size the byte lane index
//               from the RAM word width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package byte_word_bridge_pkg;

   localparam int c_STATE_W = 3;

   localparam logic [2:0] c_ST_IDLE    = 3'd0;
   localparam logic [2:0] c_ST_LOAD    = 3'd1;
   localparam logic [2:0] c_ST_RD_REQ  = 3'd2;
   localparam logic [2:0] c_ST_RD_WAIT = 3'd3;
   localparam logic [2:0] c_ST_SEND    = 3'd4;

   // Number of byte lanes in a RAM word.
   function automatic int bwb_bytes(input int data_w);
      return data_w / 8;
   endfunction

   // Width of a byte-lane index; kept at least 1 so single-byte words
   // still have a legal index vector.
   function automatic int bwb_idx_w(input int data_w);
      int b;
      b = data_w / 8;
      return (b > 1) ? $clog2(b) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bwb_word_shifter.sv
`default_nettype none
// ============================================================================
// Module      : bwb_word_shifter
// Description : Load-side word assembly register. Accepted bytes are placed
//               little-endian at the current byte index; full_o flags the
//               byte that completes a word.
// Ports       : clk, rst_n  - clock, asynchronous active-low reset
//               clr_i       - restart assembly at byte 0
//               en_i        - accept byte_i this cycle
//               byte_i      - incoming byte
//               word_o      - assembled word
//               idx_o       - index of the next byte lane to fill
//               full_o      - en_i is accepting the last lane of the word
// Revision    : 1.0 - initial release
// ============================================================================
module bwb_word_shifter
   import byte_word_bridge_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int BYTES  = bwb_bytes(DATA_W),
   localparam int IDX_W  = bwb_idx_w(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [7:0]        byte_i,
   output logic [DATA_W-1:0] word_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              full_o
);

   localparam logic [IDX_W-1:0] c_LAST = IDX_W'(BYTES - 1);

   logic [DATA_W-1:0] r_word;
   logic [IDX_W-1:0]  r_idx;
   logic              w_full;

   assign w_full = en_i && (r_idx == c_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
         r_idx  <= '0;
      end else if (clr_i) begin
         // The word itself is left alone: a flush write of the previous
         // session may still be reading it this cycle.
         r_idx <= '0;
      end else if (en_i) begin
         // Lane 0 clears the upper lanes so a partial flush pads with zeros.
         if (r_idx == '0)
            r_word <= DATA_W'(byte_i);
         else
            r_word[{r_idx, 3'b000} +: 8] <= byte_i;
         r_idx <= w_full ? '0 : r_idx + 1'b1;
      end
   end

   assign word_o = r_word;
   assign idx_o  = r_idx;
   assign full_o = w_full;

endmodule
`default_nettype wire

// File: rtl/byte_word_bridge.sv
`default_nettype none
// ============================================================================
// Module      : byte_word_bridge
// Description : Byte-serial bridge between the 8-bit pin interface and a
//               DATA_W-wide synchronous RAM. Load path packs bytes
//               little-endian into auto-incrementing word writes; readout
//               path fetches a burst of words and streams them out a byte
//               at a time under valid/ready flow control.
// Options     : BYTE_WORD_BRIDGE_CHECKSUM_EN - XOR checksum of loaded bytes
//               on chk_o (tied to 0 when undefined).
// Ports       : clk, rst_n                    - clock, async active-low reset
//               ld_start_i/ld_addr_i          - open load session at address
//               ld_valid_i/ld_byte_i/ld_ready_o - load byte handshake
//               ld_end_i                      - close session, flush partial
//               rd_start_i/rd_addr_i/rd_len_i - start readout burst
//               out_valid_o/out_byte_o/out_ready_i - output byte stream
//               mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i - RAM port
//               busy_o                        - FSM not idle
//               chk_o                         - load checksum
// Revision    : 1.0 - initial release
// ============================================================================
module byte_word_bridge
   import byte_word_bridge_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_start_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic              ld_valid_i,
   input  logic [7:0]        ld_byte_i,
   output logic              ld_ready_o,
   input  logic              ld_end_i,
   input  logic              rd_start_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [ADDR_W-1:0] rd_len_i,
   output logic              out_valid_o,
   output logic [7:0]        out_byte_o,
   input  logic              out_ready_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o,
   output logic [7:0]        chk_o
);

   localparam int               BYTES  = bwb_bytes(DATA_W);
   localparam int               IDX_W  = bwb_idx_w(DATA_W);
   localparam logic [IDX_W-1:0] c_LAST = IDX_W'(BYTES - 1);

   logic [c_STATE_W-1:0] r_state;
   logic [ADDR_W-1:0]    r_wptr;
   logic [ADDR_W-1:0]    r_waddr;
   logic                 r_we;
   logic [ADDR_W-1:0]    r_rptr;
   logic [ADDR_W-1:0]    r_rem;
   logic [DATA_W-1:0]    r_shift;
   logic [IDX_W-1:0]     r_ridx;

   logic                 w_in_load;
   logic                 w_ld_go;
   logic                 w_rd_go;
   logic                 w_ld_acc;
   logic                 w_full;
   logic                 w_flush;
   logic [DATA_W-1:0]    w_word;
   logic [IDX_W-1:0]     w_idx;

   assign w_in_load = (r_state == c_ST_LOAD);
   assign w_ld_go   = (r_state == c_ST_IDLE) && ld_start_i;
   // Load start has priority; a simultaneous read start is dropped.
   assign w_rd_go   = (r_state == c_ST_IDLE) && !ld_start_i && rd_start_i
                      && (rd_len_i != '0);
   assign w_ld_acc  = w_in_load && ld_valid_i;
   // Partial flush only when lanes remain filled after this cycle's byte;
   // a byte completing the word already produces its own write.
   assign w_flush   = w_in_load && ld_end_i
                      && (w_ld_acc ? !w_full : (w_idx != '0));

   bwb_word_shifter #(
      .DATA_W (DATA_W)
   ) u_shifter (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (w_ld_go),
      .en_i   (w_ld_acc),
      .byte_i (ld_byte_i),
      .word_o (w_word),
      .idx_o  (w_idx),
      .full_o (w_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
         r_wptr  <= '0;
         r_waddr <= '0;
         r_we    <= 1'b0;
         r_rptr  <= '0;
         r_rem   <= '0;
         r_shift <= '0;
         r_ridx  <= '0;
      end else begin
         // Write pulse lands in the cycle after the triggering byte/end;
         // after an end it falls in the first IDLE cycle.
         r_we <= (w_ld_acc && w_full) || w_flush;
         if (w_ld_acc && w_full) begin
            r_waddr <= r_wptr;
            r_wptr  <= r_wptr + 1'b1;
         end else if (w_flush) begin
            r_waddr <= r_wptr;
         end

         case (r_state)
            c_ST_IDLE: begin
               if (w_ld_go) begin
                  r_state <= c_ST_LOAD;
                  r_wptr  <= ld_addr_i;
               end else if (w_rd_go) begin
                  r_state <= c_ST_RD_REQ;
                  r_rptr  <= rd_addr_i;
                  r_rem   <= rd_len_i;
               end
            end
            c_ST_LOAD: begin
               if (ld_end_i)
                  r_state <= c_ST_IDLE;
            end
            c_ST_RD_REQ: begin
               r_state <= c_ST_RD_WAIT;
            end
            c_ST_RD_WAIT: begin
               r_shift <= mem_rdata_i;
               r_ridx  <= '0;
               r_state <= c_ST_SEND;
            end
            c_ST_SEND: begin
               if (out_ready_i) begin
                  if (r_ridx == c_LAST) begin
                     r_rem <= r_rem - 1'b1;
                     if (r_rem == ADDR_W'(1)) begin
                        r_state <= c_ST_IDLE;
                     end else begin
                        r_rptr  <= r_rptr + 1'b1;
                        r_state <= c_ST_RD_REQ;
                     end
                  end else begin
                     r_shift <= r_shift >> 8;
                     r_ridx  <= r_ridx + 1'b1;
                  end
               end
            end
            default: r_state <= c_ST_IDLE;
         endcase
      end
   end

   assign ld_ready_o  = w_in_load;
   assign out_valid_o = (r_state == c_ST_SEND);
   assign out_byte_o  = (r_state == c_ST_SEND) ? r_shift[7:0] : 8'h00;
   assign mem_we_o    = r_we;
   assign mem_wdata_o = r_we ? w_word : '0;
   assign mem_addr_o  = r_we ? r_waddr
                      : (r_state == c_ST_RD_REQ) ? r_rptr : '0;
   assign busy_o      = (r_state != c_ST_IDLE);

`ifdef BYTE_WORD_BRIDGE_CHECKSUM_EN
   logic [7:0] r_chk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_chk <= 8'h00;
      else if (w_ld_go)
         r_chk <= 8'h00;
      else if (w_ld_acc)
         r_chk <= r_chk ^ ld_byte_i;
   end

   assign chk_o = r_chk;
`else
   assign chk_o = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_byte_word_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_word_bridge
// Description : Directed self-checking bench for byte_word_bridge with a
//               behavioural synchronous RAM and write/byte scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_word_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_start_i = 1'b0;
   logic [4:0]  ld_addr_i = '0;
   logic        ld_valid_i = 1'b0;
   logic [7:0]  ld_byte_i = '0;
   logic        ld_ready_o;
   logic        ld_end_i = 1'b0;
   logic        rd_start_i = 1'b0;
   logic [4:0]  rd_addr_i = '0;
   logic [4:0]  rd_len_i = '0;
   logic        out_valid_o;
   logic [7:0]  out_byte_o;
   logic        out_ready_i = 1'b1;
   logic        mem_we_o;
   logic [4:0]  mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i = '0;
   logic        busy_o;
   logic [7:0]  chk_o;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t        wq[$];
   logic [7:0] bq[$];
   logic [31:0] ram [32];

   always #5 clk = ~clk;

   byte_word_bridge #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ld_start_i  (ld_start_i),
      .ld_addr_i   (ld_addr_i),
      .ld_valid_i  (ld_valid_i),
      .ld_byte_i   (ld_byte_i),
      .ld_ready_o  (ld_ready_o),
      .ld_end_i    (ld_end_i),
      .rd_start_i  (rd_start_i),
      .rd_addr_i   (rd_addr_i),
      .rd_len_i    (rd_len_i),
      .out_valid_o (out_valid_o),
      .out_byte_o  (out_byte_o),
      .out_ready_i (out_ready_i),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .busy_o      (busy_o),
      .chk_o       (chk_o)
   );

   // Synchronous RAM: read data appears one cycle after the address.
   always @(posedge clk) begin
      if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
      mem_rdata_i <= ram[mem_addr_o];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor, sampled mid-cycle.
   always @(negedge clk) begin
      wr_t e;
      logic [7:0] b;
      if (mem_we_o) begin
         if (wq.size() == 0) chk("wr_spurious_we", mem_we_o, 1'b0);
         else begin
            e = wq.pop_front();
            chk("wr_addr", mem_addr_o, e.a);
            chk("wr_data", mem_wdata_o, e.d);
         end
      end
      if (out_valid_o && out_ready_i) begin
         if (bq.size() == 0) chk("out_spurious", out_valid_o, 1'b0);
         else begin
            b = bq.pop_front();
            chk("out_byte", out_byte_o, b);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      wq.push_back(e);
   endtask

   task automatic ld_begin(input logic [4:0] a);
      ld_start_i = 1'b1;
      ld_addr_i  = a;
      step();
      ld_start_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      ld_valid_i = 1'b1;
      ld_byte_i  = b;
      chk("ld_ready", ld_ready_o, 1'b1);
      step();
      ld_valid_i = 1'b0;
   endtask

   task automatic ld_finish();
      ld_end_i = 1'b1;
      step();
      ld_end_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy_o && n < 40) begin
         step();
         n++;
      end
      chk(tag, busy_o, 1'b0);
   endtask

   initial begin
      logic [12:0] exp_pat;
      logic [12:0] got_pat;
      logic [7:0]  exp_chk;
      logic        seen;
      int          n;

      // ---------------- reset state ----------------
      #2;
      chk("rst_outputs", {ld_ready_o, out_valid_o, out_byte_o, mem_we_o,
                          mem_addr_o, mem_wdata_o, busy_o, chk_o}, 64'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("idle_busy", busy_o, 1'b0);
      chk("idle_ld_ready", ld_ready_o, 1'b0);

      // ---------------- full-word load ----------------
      exp_wr(5'd3, 32'h44332211);
      exp_wr(5'd4, 32'h88776655);
      ld_begin(5'd3);
      chk("load_busy", busy_o, 1'b1);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
      ld_finish();
      step();
      chk("load_idle", busy_o, 1'b0);

      // ---------------- partial flush ----------------
      exp_wr(5'd31, 32'h0000BBAA);
      ld_begin(5'd31);
      send_byte(8'hAA); send_byte(8'hBB);
      ld_finish();
      step();
      chk("flush_idle", busy_o, 1'b0);

      // ---------------- pointer wrap ----------------
      exp_wr(5'd31, 32'h04030201);
      exp_wr(5'd0,  32'h08070605);
      ld_begin(5'd31);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
      ld_finish();
      step();

      // ---------------- byte accepted together with end ----------------
      exp_wr(5'd10, 32'h0000C35A);
      ld_begin(5'd10);
      send_byte(8'h5A);
      ld_valid_i = 1'b1; ld_byte_i = 8'hC3; ld_end_i = 1'b1;
      step();
      ld_valid_i = 1'b0; ld_end_i = 1'b0;
      step();

      // ---------------- RAM preload for reads, via the load path ----------------
      exp_wr(5'd5, 32'hDEADBEEF);
      exp_wr(5'd6, 32'h01020304);
      exp_wr(5'd7, 32'hA1B2C3D4);
      ld_begin(5'd5);
      send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
      send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
      send_byte(8'hD4); send_byte(8'hC3); send_byte(8'hB2); send_byte(8'hA1);
      ld_finish();
      step();

      // ---------------- burst read, full rate ----------------
      bq.push_back(8'hEF); bq.push_back(8'hBE); bq.push_back(8'hAD); bq.push_back(8'hDE);
      bq.push_back(8'h04); bq.push_back(8'h03); bq.push_back(8'h02); bq.push_back(8'h01);
      out_ready_i = 1'b1;
      rd_start_i = 1'b1; rd_addr_i = 5'd5; rd_len_i = 5'd2;
      step();
      rd_start_i = 1'b0;
      exp_pat = 13'b0_1111_00_1111_00;
      got_pat = '0;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         got_pat[k] = out_valid_o;
      end
      chk("rd_valid_pattern", got_pat, exp_pat);
      chk("rd_busy_after", busy_o, 1'b0);
      step();

      // ---------------- zero-length read is ignored ----------------
      rd_start_i = 1'b1; rd_addr_i = 5'd5; rd_len_i = 5'd0;
      step();
      rd_start_i = 1'b0;
      chk("rd_len0_busy", busy_o, 1'b0);

      // ---------------- backpressure mid-word ----------------
      bq.push_back(8'hD4); bq.push_back(8'hC3); bq.push_back(8'hB2); bq.push_back(8'hA1);
      out_ready_i = 1'b0;
      rd_start_i = 1'b1; rd_addr_i = 5'd7; rd_len_i = 5'd1;
      step();
      rd_start_i = 1'b0;
      n = 0;
      while (!out_valid_o && n < 10) begin
         step();
         n++;
      end
      chk("bp_valid_timeout", out_valid_o, 1'b1);
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("bp_hold_valid", out_valid_o, 1'b1);
         chk("bp_hold_byte", out_byte_o, 8'hC3);
         step();
      end
      out_ready_i = 1'b1;
      wait_idle("bp_idle");

      // ---------------- simultaneous starts ----------------
      ld_start_i = 1'b1; ld_addr_i = 5'd12;
      rd_start_i = 1'b1; rd_addr_i = 5'd5; rd_len_i = 5'd1;
      step();
      ld_start_i = 1'b0; rd_start_i = 1'b0;
      chk("both_load_wins", ld_ready_o, 1'b1);
      ld_finish();
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         seen = seen | out_valid_o | busy_o;
         step();
      end
      chk("both_no_read", seen, 1'b0);

      // ---------------- checksum ----------------
`ifdef BYTE_WORD_BRIDGE_CHECKSUM_EN
      exp_chk = 8'h0F ^ 8'hF0 ^ 8'h3C;
`else
      exp_chk = 8'h00;
`endif
      exp_wr(5'd20, 32'h003CF00F);
      ld_begin(5'd20);
      send_byte(8'h0F); send_byte(8'hF0); send_byte(8'h3C);
      ld_finish();
      step();
      step();
      chk("checksum", chk_o, exp_chk);

      // ---------------- reset mid-burst ----------------
      bq.push_back(8'hEF); bq.push_back(8'hBE); bq.push_back(8'hAD); bq.push_back(8'hDE);
      bq.push_back(8'h04); bq.push_back(8'h03); bq.push_back(8'h02); bq.push_back(8'h01);
      rd_start_i = 1'b1; rd_addr_i = 5'd5; rd_len_i = 5'd2;
      step();
      rd_start_i = 1'b0;
      n = 0;
      while (!out_valid_o && n < 10) begin
         step();
         n++;
      end
      chk("rst_burst_valid_timeout", out_valid_o, 1'b1);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_outputs", {ld_ready_o, out_valid_o, out_byte_o, mem_we_o,
                                mem_addr_o, mem_wdata_o, busy_o, chk_o}, 64'd0);
      bq.delete();
      step();
      rst_n = 1'b1;
      step();
      step();
      chk("rst_release_idle", busy_o, 1'b0);
      chk("rst_release_valid", out_valid_o, 1'b0);

      // ---------------- scoreboard drained ----------------
      chk("wr_queue_empty", wq.size(), 0);
      chk("byte_queue_empty", bq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
